// File: rtl/mux8_rr_collect_pkg.sv
// Shared constants and helpers for the 8-channel round-robin collector.
package mux8_rr_collect_pkg;

    localparam int NUM_CH     = 8;
    localparam int SEL_W      = 3;
    localparam int DATA_W_DEF = 16;

    // Rotate right so that bit 'n' of v lands at bit 0.
    function automatic logic [NUM_CH-1:0] rot_r8(input logic [NUM_CH-1:0] v,
                                                  input logic [SEL_W-1:0]  n);
        logic [2*NUM_CH-1:0] w_dbl;
        w_dbl = {v, v} >> n;
        return w_dbl[NUM_CH-1:0];
    endfunction

endpackage

// File: rtl/mux8_rr_collect_rr_pick8.sv
// Combinational round-robin picker: first requester at or after ptr (mod 8).
// Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
module rr_pick8
    import mux8_rr_collect_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any
);

    logic [NUM_CH-1:0] w_rot;
    logic [SEL_W-1:0]  w_pos;

    always_comb begin
        w_rot = rot_r8(req, ptr);
        w_pos = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) w_pos = SEL_W'(k);
        end
        any     = |req;
        gnt_idx = w_pos + ptr;
        gnt     = any ? (NUM_CH'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mux8_rr_collect.sv
// 8-to-1 round-robin collector: merges eight sample streams, tags each word with its source.
// One-entry registered output; accepts a new word whenever empty or draining this cycle.
module mux8_rr_collect
    import mux8_rr_collect_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  r_rr_ptr;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_sel;
    logic              r_out_valid;

    logic [NUM_CH-1:0] w_gnt;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic              w_any;
    logic              w_load_en;
    logic              w_accept;

    rr_pick8 u_pick (
        .req     (in_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // Reset suppresses the handshake so no upstream word is lost during reset.
    assign w_load_en = !r_out_valid || out_ready;
    assign w_accept  = w_any && w_load_en && !reset;
    assign in_ready  = w_accept ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_gnt_idx*DATA_W +: DATA_W];
            r_out_sel   <= w_gnt_idx;
            r_rr_ptr    <= w_gnt_idx + SEL_W'(1);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
